piso_rr_scheduler: RTL and testbench

PISO_RR_SCHEDULER -- requirements
Module: piso_rr_scheduler

---
 rtl/piso_rr_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_piso_rr_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_rr_scheduler.sv
// piso_rr_scheduler
//   Round-robin scheduler feeding a parallel-in/serial-out shifter. Requesters
//   present a word on din with req held; the winner gets a one-cycle gnt pulse
//   and its word is serialized LSB first, one bit per clock, with framing
//   strobes and the owner index. Frames can run back-to-back with no gap.
//
//   Optional feature: define PISO_RR_SCHEDULER_PARITY_EN to append an even
//   parity bit after the data bits (frame length DATA_WIDTH+1).
//
// Ports
//   clk         clock, all state on rising edge
//   reset       asynchronous, active-high reset
//   req         per-requester word pending
//   din         packed words, word i at din[i*DATA_WIDTH +: DATA_WIDTH]
//   gnt         one-hot acceptance pulse, word captured on that edge
//   dout        serial data, LSB first
//   dout_valid  dout carries a frame bit
//   dout_first  first bit of frame (data bit 0)
//   dout_last   final bit of frame
//   dout_id     requester owning the current frame
module piso_rr_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          dout,
    output logic                          dout_valid,
    output logic                          dout_first,
    output logic                          dout_last,
    output logic [$clog2(NUM_REQ)-1:0]    dout_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(DATA_WIDTH);
    localparam int unsigned NR = NUM_REQ;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef PISO_RR_SCHEDULER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t                state;
    state_t                nxt;
    logic [IDW-1:0]        p;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
`ifdef PISO_RR_SCHEDULER_PARITY_EN
    logic                  par;
`endif

    logic                  found;
    logic [IDW-1:0]        win;
    int unsigned           idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  last_bit;
    logic                  grant_ok;
    logic                  take;

    // Round-robin pick: first set req scanning upward from p, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(p) + i) % NR;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (win == IDW'(i)) begin
                word = din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_bit = (state == SHIFT) && (cnt == LAST);

    // Grants are only offered when the shifter is free next cycle: in IDLE or
    // on the final cycle of the current frame.
`ifdef PISO_RR_SCHEDULER_PARITY_EN
    assign grant_ok = (state == IDLE) || (state == PARITY);
`else
    assign grant_ok = (state == IDLE) || last_bit;
`endif
    assign take = grant_ok && found;

    always_comb begin
        gnt = '0;
        if (take && !reset) begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (win == IDW'(i)) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (take) nxt = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PISO_RR_SCHEDULER_PARITY_EN
                    nxt = PARITY;
`else
                    nxt = take ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_RR_SCHEDULER_PARITY_EN
            PARITY: begin
                nxt = take ? SHIFT : IDLE;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            p       <= '0;
            cnt     <= '0;
            shreg   <= '0;
            dout_id <= '0;
`ifdef PISO_RR_SCHEDULER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (take) begin
                shreg   <= word;
                dout_id <= win;
                cnt     <= '0;
                p       <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef PISO_RR_SCHEDULER_PARITY_EN
                par     <= ^word;
`endif
            end else if (state == SHIFT) begin
                shreg <= shreg >> 1;
                cnt   <= last_bit ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        dout_first = 1'b0;
        dout_last  = 1'b0;
        if (state == SHIFT) begin
            dout       = shreg[0];
            dout_valid = 1'b1;
            dout_first = (cnt == '0);
`ifndef PISO_RR_SCHEDULER_PARITY_EN
            dout_last  = last_bit;
`endif
        end
`ifdef PISO_RR_SCHEDULER_PARITY_EN
        if (state == PARITY) begin
            dout       = par;
            dout_valid = 1'b1;
            dout_last  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Directed bench for piso_rr_scheduler (DATA_WIDTH=16, NUM_REQ=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 unit later, well before the next edge.
module tb_piso_rr_scheduler;

    localparam int DW = 16;
    localparam int NR = 4;
`ifdef PISO_RR_SCHEDULER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] din;
    logic [NR-1:0]   gnt;
    logic            dout;
    logic            dout_valid;
    logic            dout_first;
    logic            dout_last;
    logic [1:0]      dout_id;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [DW-1:0] W0 = 16'hA5C3;
    localparam logic [DW-1:0] W1 = 16'h1234;
    localparam logic [DW-1:0] W2 = 16'h5A0F;
    localparam logic [DW-1:0] W3 = 16'h8001;

    piso_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .dout_id    (dout_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Checks all outputs of the idle state.
    task automatic idle_chk(input logic [1:0] exp_id);
        @(posedge clk); #1; #1;
        check("idle_valid", 64'(dout_valid), 64'(0));
        check("idle_dout",  64'(dout), 64'(0));
        check("idle_first", 64'(dout_first), 64'(0));
        check("idle_last",  64'(dout_last), 64'(0));
        check("idle_gnt",   64'(gnt), 64'(0));
        check("idle_id",    64'(dout_id), 64'(exp_id));
    endtask

    // Called in the grant cycle. Walks the whole frame; req is replaced with
    // req0 at bit 0, req_mid at bit 4 and req_end at bit 10. gnt must be zero
    // except on the final frame cycle, where it must equal gnt_last.
    task automatic frame(input logic [1:0] id, input logic [DW-1:0] w,
                         input logic [NR-1:0] req0, input logic [NR-1:0] req_mid,
                         input logic [NR-1:0] req_end, input logic [NR-1:0] gnt_last);
        logic exp_bit;
        for (int i = 0; i < FL; i++) begin
            @(posedge clk); #1;
            if (i == 0)  req = req0;
            if (i == 4)  req = req_mid;
            if (i == 10) req = req_end;
            #1;
            exp_bit = (i < DW) ? w[i] : ^w;
            check("f_dout",  64'(dout), 64'(exp_bit));
            check("f_valid", 64'(dout_valid), 64'(1));
            check("f_first", 64'(dout_first), 64'(i == 0));
            check("f_last",  64'(dout_last), 64'(i == FL - 1));
            check("f_id",    64'(dout_id), 64'(id));
            check("f_gnt",   64'(gnt), (i == FL - 1) ? 64'(gnt_last) : 64'(0));
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        din   = {W3, W2, W1, W0};

        // Reset state, no grant while reset is high even with requests.
        @(posedge clk); #1; #1;
        check("rst_gnt",   64'(gnt), 64'(0));
        check("rst_valid", 64'(dout_valid), 64'(0));
        check("rst_dout",  64'(dout), 64'(0));
        check("rst_first", 64'(dout_first), 64'(0));
        check("rst_last",  64'(dout_last), 64'(0));
        check("rst_id",    64'(dout_id), 64'(0));
        req = '0;

        // Single frame from requester 0, word A5C3.
        @(posedge clk); #1;
        reset = 1'b0;
        req   = 4'b0001;
        #1;
        check("t1_gnt", 64'(gnt), 64'(4'b0001));
        frame(2'd0, W0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd0);

        // p=1: req 0001 still wins 0; req[2] pulsed mid-frame is ignored.
        @(posedge clk); #1;
        req = 4'b0001;
        #1;
        check("t2_gnt", 64'(gnt), 64'(4'b0001));
        frame(2'd0, W0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        idle_chk(2'd0);

        // Requester 1 alone; afterwards p=2.
        @(posedge clk); #1;
        req = 4'b0010;
        #1;
        check("t3_gnt", 64'(gnt), 64'(4'b0010));
        frame(2'd1, W1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd1);

        // p=2, req 0011: wrap grants 0, then 1 back-to-back.
        @(posedge clk); #1;
        req = 4'b0011;
        #1;
        check("wrap_gnt0", 64'(gnt), 64'(4'b0001));
        frame(2'd0, W0, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        frame(2'd1, W1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd1);

        // p=2, req 0010 -> grant 1, then reset at data bit 7.
        @(posedge clk); #1;
        req = 4'b0010;
        #1;
        check("ab_gnt", 64'(gnt), 64'(4'b0010));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) req = 4'b0000;
            #1;
        end
        check("ab_bit7", 64'(dout), 64'(W1[7]));
        check("ab_id",   64'(dout_id), 64'(1));
        #1;
        reset = 1'b1;
        req   = 4'b0100;
        #1;
        check("ab_rst_valid", 64'(dout_valid), 64'(0));
        check("ab_rst_dout",  64'(dout), 64'(0));
        check("ab_rst_first", 64'(dout_first), 64'(0));
        check("ab_rst_last",  64'(dout_last), 64'(0));
        check("ab_rst_id",    64'(dout_id), 64'(0));
        check("ab_rst_gnt",   64'(gnt), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ab_rel_gnt", 64'(gnt), 64'(4'b0100));
        frame(2'd2, W2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd2);

        // Reset again (p back to 0), then all requesting: order 0,1,2,3,0.
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        check("rr_gnt0", 64'(gnt), 64'(4'b0001));
        frame(2'd0, W0, 4'b1111, 4'b1111, 4'b1111, 4'b0010);
        frame(2'd1, W1, 4'b1111, 4'b1111, 4'b1111, 4'b0100);
        frame(2'd2, W2, 4'b1111, 4'b1111, 4'b1111, 4'b1000);
        frame(2'd3, W3, 4'b1111, 4'b1111, 4'b1111, 4'b0001);
        frame(2'd0, W0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd0);

        // Word 0007 (parity 1 when the parity bit is built in).
        @(posedge clk); #1;
        din = {W3, W2, W1, 16'h0007};
        req = 4'b0001;
        #1;
        check("par_gnt", 64'(gnt), 64'(4'b0001));
        frame(2'd0, 16'h0007, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        idle_chk(2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
